// File: rtl/dvi_tmds_encoder.sv
// dvi_tmds_encoder: turns the scan converter's RGB332 VGA stream into three DVI TMDS
// symbols per pixel through a fixed three-stage pipeline (capture, q_m, DC balance).
`timescale 1ns/1ps
module dvi_tmds_encoder #(
    parameter logic SYNC_INVERT = 1'b0,
    parameter logic EXPAND_MODE = 1'b0
) (
    input  logic       clk25m,
    input  logic       reset_n,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic       blank_i,
    input  logic [7:0] rgb_i,
    output logic [9:0] tmds_b,
    output logic [9:0] tmds_g,
    output logic [9:0] tmds_r,
    output logic       de_o
);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [8:0] tmds_qm(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] qm;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        qm       = '0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        qm[8] = ~use_xnor;
        return qm;
    endfunction

    // Returns {symbol, next disparity}; disparity is the running ones-minus-zeros balance.
    function automatic logic [14:0] tmds_balance(input logic [8:0] qm, input logic [3:0] n1q,
                                                 input logic signed [4:0] cnt);
        logic signed [4:0] n1;
        logic signed [4:0] n0;
        logic signed [4:0] diff;
        logic signed [4:0] bias;
        logic signed [4:0] nxt;
        logic [9:0]        sym;
        n1   = $signed({1'b0, n1q});
        n0   = 5'sd8 - n1;
        diff = n1 - n0;
        bias = qm[8] ? 5'sd2 : 5'sd0;
        if ((cnt == 5'sd0) || (n1 == n0)) begin
            sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            nxt = qm[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 5'sd0) && (n1 > n0)) || ((cnt < 5'sd0) && (n0 > n1))) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            nxt = cnt + bias - diff;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            nxt = cnt + diff - (5'sd2 - bias);
        end
        return {sym, nxt};
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = CTRL_00;
            2'b01:   t = CTRL_01;
            2'b10:   t = CTRL_10;
            default: t = CTRL_11;
        endcase
        return t;
    endfunction

    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;

    logic            hsync_s1_d, hsync_s1_q;
    logic            vsync_s1_d, vsync_s1_q;
    logic            de_s1_d, de_s1_q;
    logic [2:0][7:0] color_s1_d, color_s1_q;

    logic            hsync_s2_d, hsync_s2_q;
    logic            vsync_s2_d, vsync_s2_q;
    logic            de_s2_d, de_s2_q;
    logic [2:0][8:0] qm_s2_d, qm_s2_q;
    logic [2:0][3:0] n1q_s2_d, n1q_s2_q;

    logic            de_s3_d, de_s3_q;
    logic [2:0][9:0] sym_s3_d, sym_s3_q;
    logic [2:0][4:0] cnt_s3_d, cnt_s3_q;

    assign red   = rgb_i[7:5];
    assign green = rgb_i[4:2];
    assign blue  = rgb_i[1:0];

    // Channel index order is blue, green, red to match TMDS channels 0..2.
    always_comb begin
        hsync_s1_d = hsync_i ^ SYNC_INVERT;
        vsync_s1_d = vsync_i ^ SYNC_INVERT;
        de_s1_d    = ~blank_i;
        if (EXPAND_MODE) begin
            color_s1_d[2] = {red, 5'b00000};
            color_s1_d[1] = {green, 5'b00000};
            color_s1_d[0] = {blue, 6'b000000};
        end else begin
            color_s1_d[2] = {red, red, red[2:1]};
            color_s1_d[1] = {green, green, green[2:1]};
            color_s1_d[0] = {blue, blue, blue, blue};
        end
    end

    always_comb begin
        hsync_s2_d = hsync_s1_q;
        vsync_s2_d = vsync_s1_q;
        de_s2_d    = de_s1_q;
        for (int ch = 0; ch < 3; ch++) begin
            qm_s2_d[ch]  = tmds_qm(color_s1_q[ch]);
            n1q_s2_d[ch] = popcount8(qm_s2_d[ch][7:0]);
        end
    end

    // Blanking forces control tokens and clears disparity so each active run starts balanced.
    always_comb begin
        de_s3_d = de_s2_q;
        for (int ch = 0; ch < 3; ch++) begin
            if (!de_s2_q) begin
                sym_s3_d[ch] = (ch == 0) ? ctrl_token({vsync_s2_q, hsync_s2_q}) : CTRL_00;
                cnt_s3_d[ch] = '0;
            end else begin
                {sym_s3_d[ch], cnt_s3_d[ch]} = tmds_balance(qm_s2_q[ch], n1q_s2_q[ch],
                                                            $signed(cnt_s3_q[ch]));
            end
        end
    end

    always_ff @(posedge clk25m or negedge reset_n) begin
        if (!reset_n) begin
            hsync_s1_q <= 1'b0;
            vsync_s1_q <= 1'b0;
            de_s1_q    <= 1'b0;
            color_s1_q <= '0;
            hsync_s2_q <= 1'b0;
            vsync_s2_q <= 1'b0;
            de_s2_q    <= 1'b0;
            qm_s2_q    <= '0;
            n1q_s2_q   <= '0;
            de_s3_q    <= 1'b0;
            sym_s3_q   <= {3{CTRL_00}};
            cnt_s3_q   <= '0;
        end else begin
            hsync_s1_q <= hsync_s1_d;
            vsync_s1_q <= vsync_s1_d;
            de_s1_q    <= de_s1_d;
            color_s1_q <= color_s1_d;
            hsync_s2_q <= hsync_s2_d;
            vsync_s2_q <= vsync_s2_d;
            de_s2_q    <= de_s2_d;
            qm_s2_q    <= qm_s2_d;
            n1q_s2_q   <= n1q_s2_d;
            de_s3_q    <= de_s3_d;
            sym_s3_q   <= sym_s3_d;
            cnt_s3_q   <= cnt_s3_d;
        end
    end

    assign tmds_b = sym_s3_q[0];
    assign tmds_g = sym_s3_q[1];
    assign tmds_r = sym_s3_q[2];
    assign de_o   = de_s3_q;

endmodule
